bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 16 +
 rtl/bus_arbiter_if.sv | 27 ++
 rtl/bus_arbiter_rr_priority_picker.sv | 31 +++
 rtl/bus_arbiter.sv | 114 +++++++++++
 tb/tb_bus_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding and parameter defaults.
package bus_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEFAULT       = 4;
    localparam int unsigned BEGIN_TIMEOUT_DEFAULT = 16;
    localparam int unsigned IDX_W                 = 3;
    localparam int unsigned CNT_W                 = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester/bus side of the arbiter: requests and grants plus the observed bus phases.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT
) ();

    logic [NUM_REQ-1:0] request;
    logic [NUM_REQ-1:0] grant;
    logic               begin_transactionIN;
    logic               end_transactionIN;
    logic               errorIN;
    logic               timeout_pulse;
    logic [1:0]         arbiter_state;
    logic [IDX_W-1:0]   owner;

    modport master (
        input  request, begin_transactionIN, end_transactionIN, errorIN,
        output grant, timeout_pulse, arbiter_state, owner
    );

    modport slave (
        output request, begin_transactionIN, end_transactionIN, errorIN,
        input  grant, timeout_pulse, arbiter_state, owner
    );

endinterface

// File: rtl/bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after last_owner+1 (mod NUM_REQ).
module rr_priority_picker
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [IDX_W-1:0]   winner,
    output logic               any_request
);

    logic [7:0]  req_pad;
    int unsigned pos;

    assign req_pad     = 8'(request);
    assign any_request = |request;

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        winner = '0;
        pos    = 0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            pos = (32'(last_owner) + i) % NUM_REQ;
            if (req_pad[3'(pos)]) begin
                winner = 3'(pos);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with begin-timeout revocation and one-cycle bus turnaround.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ       = NUM_REQ_DEFAULT,
    parameter int unsigned BEGIN_TIMEOUT = BEGIN_TIMEOUT_DEFAULT
) (
    input  logic          clock,
    input  logic          n_reset,
    bus_arbiter_if.master bus
);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               timeout_q, timeout_d;

    logic [IDX_W-1:0]   winner;
    logic               any_request;
    logic [7:0]         req_pad;
    logic               bus_done;

    assign req_pad  = 8'(bus.request);
    assign bus_done = bus.end_transactionIN | bus.errorIN;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .request     (bus.request),
        .last_owner  (last_owner_q),
        .winner      (winner),
        .any_request (any_request)
    );

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= 3'(NUM_REQ - 1);
            count_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            count_q      <= count_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        count_d      = '0;
        timeout_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any_request) begin
                    state_d      = ST_GRANTED;
                    grant_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                    owner_d      = winner;
                    last_owner_d = winner;
                end
            end
            ST_GRANTED: begin
                // A begin takes precedence over both a dropped request and counter expiry.
                if (bus.begin_transactionIN) begin
                    if (bus_done) begin
                        state_d = ST_RELEASE;
                        grant_d = '0;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else if (!req_pad[owner_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (count_q == 8'(BEGIN_TIMEOUT - 1)) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            ST_ACTIVE: begin
                if (bus_done) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.grant         = grant_q;
    assign bus.timeout_pulse = timeout_q;
    assign bus.arbiter_state = state_q;
    assign bus.owner         = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected {timeout, state, owner, grant} queued per step.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int unsigned NREQ = 4;

    logic clock = 1'b0;
    logic n_reset;

    always #5 clock = ~clock;

    bus_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    bus_arbiter #(
        .NUM_REQ       (NREQ),
        .BEGIN_TIMEOUT (16)
    ) dut (
        .clock   (clock),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int tests  = 0;
    int failed = 0;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    function automatic logic [9:0] pk(logic to, logic [1:0] st, logic [2:0] own, logic [3:0] g);
        return {to, st, own, g};
    endfunction

    task automatic drive(logic [3:0] req, logic b, logic e, logic er);
        bus.request             = req;
        bus.begin_transactionIN = b;
        bus.end_transactionIN   = e;
        bus.errorIN             = er;
    endtask

    task automatic expect_out(string tag, logic [9:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check_now();
        logic [9:0] obs;
        logic [9:0] exp_v;
        string      tag;
        obs = {bus.timeout_pulse, bus.arbiter_state, bus.owner, bus.grant};
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL scoreboard_empty observed=%h required=<entry>", obs);
        end else begin
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            assert (obs === exp_v) else begin
                failed++;
                $error("FAIL %s observed{to,st,own,grant}=%b_%b_%b_%b required=%b_%b_%b_%b",
                       tag, obs[9], obs[8:7], obs[6:4], obs[3:0],
                       exp_v[9], exp_v[8:7], exp_v[6:4], exp_v[3:0]);
            end
        end
    endtask

    task automatic step(string tag, logic [9:0] v);
        expect_out(tag, v);
        @(posedge clock);
        @(negedge clock);
        check_now();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] g;
        n_reset = 1'b0;
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        #3;
        expect_out("reset_state", pk(1'b0, ST_IDLE, 3'd0, 4'b0000));
        check_now();
        @(negedge clock);
        @(negedge clock);
        n_reset = 1'b1;

        // Single requester: grant, begin, end, one turnaround cycle
        drive(4'b0001, 1'b0, 1'b0, 1'b0);
        step("single_grant", pk(1'b0, ST_GRANTED, 3'd0, 4'b0001));
        drive(4'b0001, 1'b1, 1'b0, 1'b0);
        step("single_active", pk(1'b0, ST_ACTIVE, 3'd0, 4'b0001));
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        step("single_release", pk(1'b0, ST_RELEASE, 3'd0, 4'b0000));
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        step("single_idle", pk(1'b0, ST_IDLE, 3'd0, 4'b0000));

        // Round robin from reset with all requesting
        n_reset = 1'b0;
        @(negedge clock);
        n_reset = 1'b1;
        drive(4'b1111, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << (k % 4);
            step($sformatf("rr_grant%0d", k), pk(1'b0, ST_GRANTED, 3'(k % 4), g));
            drive(4'b1111, 1'b1, 1'b0, 1'b0);
            step($sformatf("rr_active%0d", k), pk(1'b0, ST_ACTIVE, 3'(k % 4), g));
            drive(4'b1111, 1'b0, 1'b1, 1'b0);
            step($sformatf("rr_release%0d", k), pk(1'b0, ST_RELEASE, 3'(k % 4), 4'b0000));
            drive(4'b1111, 1'b0, 1'b0, 1'b0);
            step($sformatf("rr_idle%0d", k), pk(1'b0, ST_IDLE, 3'(k % 4), 4'b0000));
        end

        // Begin timeout on requester 1, then requester 2 wins
        step("to_grant", pk(1'b0, ST_GRANTED, 3'd1, 4'b0010));
        for (int k = 1; k <= 15; k++) begin
            step($sformatf("to_wait%0d", k), pk(1'b0, ST_GRANTED, 3'd1, 4'b0010));
        end
        step("to_pulse", pk(1'b1, ST_IDLE, 3'd1, 4'b0000));
        step("to_next_grant", pk(1'b0, ST_GRANTED, 3'd2, 4'b0100));

        // Begin on the last counter cycle wins over timeout
        for (int k = 1; k <= 15; k++) begin
            step($sformatf("late_wait%0d", k), pk(1'b0, ST_GRANTED, 3'd2, 4'b0100));
        end
        drive(4'b1111, 1'b1, 1'b0, 1'b0);
        step("late_begin", pk(1'b0, ST_ACTIVE, 3'd2, 4'b0100));

        // Request changes during ACTIVE leave the grant alone
        drive(4'b1011, 1'b0, 1'b0, 1'b0);
        step("active_req_a", pk(1'b0, ST_ACTIVE, 3'd2, 4'b0100));
        drive(4'b1111, 1'b0, 1'b0, 1'b0);
        step("active_req_b", pk(1'b0, ST_ACTIVE, 3'd2, 4'b0100));
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        step("active_req_c", pk(1'b0, ST_ACTIVE, 3'd2, 4'b0100));
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        step("error_release", pk(1'b0, ST_RELEASE, 3'd2, 4'b0000));
        drive(4'b0000, 1'b1, 1'b0, 1'b0);
        step("release_ignores_begin", pk(1'b0, ST_IDLE, 3'd2, 4'b0000));
        drive(4'b0000, 1'b1, 1'b1, 1'b0);
        step("idle_ignores_bus", pk(1'b0, ST_IDLE, 3'd2, 4'b0000));

        // Begin together with error in GRANTED goes straight to RELEASE
        drive(4'b1000, 1'b0, 1'b0, 1'b0);
        step("be_grant", pk(1'b0, ST_GRANTED, 3'd3, 4'b1000));
        drive(4'b1000, 1'b1, 1'b0, 1'b1);
        step("be_release", pk(1'b0, ST_RELEASE, 3'd3, 4'b0000));
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        step("be_idle", pk(1'b0, ST_IDLE, 3'd3, 4'b0000));

        // Owner withdraws before begin
        drive(4'b0011, 1'b0, 1'b0, 1'b0);
        step("drop_grant", pk(1'b0, ST_GRANTED, 3'd0, 4'b0001));
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        step("drop_idle", pk(1'b0, ST_IDLE, 3'd0, 4'b0000));
        step("drop_next", pk(1'b0, ST_GRANTED, 3'd1, 4'b0010));

        // Asynchronous reset mid-transaction
        drive(4'b0010, 1'b1, 1'b0, 1'b0);
        step("pre_reset_active", pk(1'b0, ST_ACTIVE, 3'd1, 4'b0010));
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        #2;
        n_reset = 1'b0;
        #1;
        expect_out("async_reset", pk(1'b0, ST_IDLE, 3'd0, 4'b0000));
        check_now();
        @(negedge clock);
        n_reset = 1'b1;
        drive(4'b1111, 1'b0, 1'b0, 1'b0);
        step("post_reset_grant", pk(1'b0, ST_GRANTED, 3'd0, 4'b0001));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
